// File: rtl/regarb_pkg.sv
// regarb_pkg: shared request type, zero-register constant, FIFO depth and hazard-match helper
// Ports: none (package).
package regarb_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam logic [4:0] XZR = 5'd31;
  typedef struct packed {
    logic [4:0]  rg;
    logic [63:0] data;
  } wr_req_t;
  function automatic logic hit(input logic [4:0] rd, input wr_req_t e, input logic v);
    return v && rd != XZR && e.rg == rd;
  endfunction
endpackage

// File: rtl/regwrite_arbiter_if.sv
// regwrite_arbiter_if: request handshakes, register-file write port and hazard signals
// Ports: master = requester/decode side driving requests and read numbers, slave = arbiter.
interface regwrite_arbiter_if;
  logic        wb_valid, wb_ready, mc_valid, mc_ready;
  logic [4:0]  wb_reg, mc_reg, rd_reg1, rd_reg2, WriteRegister;
  logic [63:0] wb_data, mc_data, WriteData;
  logic        RegWrite, stall, busy;
  modport master (
    output wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data, rd_reg1, rd_reg2,
    input  wb_ready, mc_ready, RegWrite, WriteRegister, WriteData, stall, busy
  );
  modport slave (
    input  wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data, rd_reg1, rd_reg2,
    output wb_ready, mc_ready, RegWrite, WriteRegister, WriteData, stall, busy
  );
endinterface

// File: rtl/wr_fifo2.sv
// wr_fifo2: 2-entry request FIFO with head at entry 0 and all entries exposed for hazard checks
// Ports: clk/reset, push_i/din_i write side, pop_i removes head, ent_o/vld_o contents, full_o.
module wr_fifo2
  import regarb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wr_req_t                  din_i,
  output wr_req_t [FIFO_DEPTH-1:0] ent_o,
  output logic    [FIFO_DEPTH-1:0] vld_o,
  output logic                     full_o
);
  wr_req_t [FIFO_DEPTH-1:0] ent_q, ent_d;
  logic [1:0] cnt_q, cnt_d;
  // Pop shifts entry 1 down; push then lands in the first free slot after that shift.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q - {1'b0, pop_i};
    if (pop_i) ent_d[0] = ent_q[1];
    if (push_i) ent_d[cnt_d[0]] = din_i;
    cnt_d = cnt_d + {1'b0, push_i};
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? 2'd0 : cnt_d;
    ent_q <= reset ? '0 : ent_d;
  end
  assign ent_o  = ent_q;
  assign vld_o  = {cnt_q[1], cnt_q != 2'd0};
  assign full_o = cnt_q[1];
endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: arbitrates writeback and multi-cycle register writes onto one register-file port
// Ports: clk, reset (sync, active-high), bus (regwrite_arbiter_if.slave: wb/mc handshakes,
//   RegWrite/WriteRegister/WriteData, rd_reg1/rd_reg2 -> stall, busy).
// Macro REGWRITE_ARB_STARVE_EN enables the mc starvation guard; otherwise wb strictly wins.
module regwrite_arbiter
  import regarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  regwrite_arbiter_if.slave bus
);
  wr_req_t [FIFO_DEPTH-1:0] wb_ent, mc_ent;
  logic [FIFO_DEPTH-1:0] wb_vld, mc_vld;
  logic wb_full, mc_full, gnt_wb, gnt_mc, hit_any, out_vld_q, out_vld_d;
  wr_req_t wb_in, mc_in, head, out_q, out_d;
  assign wb_in = {bus.wb_reg, bus.wb_data};
  assign mc_in = {bus.mc_reg, bus.mc_data};
  wr_fifo2 u_wb (
    .clk(clk), .reset(reset), .push_i(bus.wb_valid && !wb_full), .pop_i(gnt_wb),
    .din_i(wb_in), .ent_o(wb_ent), .vld_o(wb_vld), .full_o(wb_full)
  );
  wr_fifo2 u_mc (
    .clk(clk), .reset(reset), .push_i(bus.mc_valid && !mc_full), .pop_i(gnt_mc),
    .din_i(mc_in), .ent_o(mc_ent), .vld_o(mc_vld), .full_o(mc_full)
  );
`ifdef REGWRITE_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] sc_q, sc_d;
  // Counts cycles mc waits behind wb; reaching the limit forces one mc grant.
  assign gnt_mc = mc_vld[0] && (!wb_vld[0] || sc_q == CW'(STARVE_LIMIT));
  assign sc_d   = (!mc_vld[0] || gnt_mc) ? '0 : sc_q + 1'b1;
  always_ff @(posedge clk) sc_q <= reset ? '0 : sc_d;
`else
  logic unused_limit;
  assign unused_limit = STARVE_LIMIT != 0;
  assign gnt_mc = mc_vld[0] && !wb_vld[0];
`endif
  assign gnt_wb    = wb_vld[0] && !gnt_mc;
  assign head      = gnt_mc ? mc_ent[0] : wb_ent[0];
  // Writes to the zero register are popped but never reach the write port.
  assign out_vld_d = (gnt_wb || gnt_mc) && head.rg != XZR;
  assign out_d     = out_vld_d ? head : '0;
  always_ff @(posedge clk) begin
    out_vld_q <= reset ? 1'b0 : out_vld_d;
    out_q     <= reset ? '0 : out_d;
  end
  always_comb begin
    hit_any = hit(bus.rd_reg1, out_q, out_vld_q) || hit(bus.rd_reg2, out_q, out_vld_q);
    for (int i = 0; i < FIFO_DEPTH; i++)
      hit_any = hit_any || hit(bus.rd_reg1, wb_ent[i], wb_vld[i]) || hit(bus.rd_reg2, wb_ent[i], wb_vld[i])
                        || hit(bus.rd_reg1, mc_ent[i], mc_vld[i]) || hit(bus.rd_reg2, mc_ent[i], mc_vld[i]);
  end
  assign bus.wb_ready      = !wb_full;
  assign bus.mc_ready      = !mc_full;
  assign bus.RegWrite      = out_vld_q && !reset;
  assign bus.WriteRegister = reset ? 5'd0 : out_q.rg;
  assign bus.WriteData     = reset ? 64'd0 : out_q.data;
  assign bus.stall         = hit_any && !reset;
  assign bus.busy          = !reset && (wb_vld[0] || mc_vld[0] || out_vld_q);
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed table, corner sequences and random traffic against a queue model
module tb_regwrite_arbiter;
  import regarb_pkg::*;
  localparam int LIMIT = 4;
`ifdef REGWRITE_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  regwrite_arbiter_if ifc();
  regwrite_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  int checks = 0;
  int errors = 0;
  wr_req_t wbq[$];
  wr_req_t mcq[$];
  int sc = 0;
  logic exp_rw = 1'b0;
  logic [4:0] exp_wreg = 5'd0;
  logic [63:0] exp_wdata = 64'd0;
  typedef struct {
    int r, wv, wr; logic [63:0] wd;
    int mv, mr; logic [63:0] md;
    int rd1, rd2, rw, wreg; logic [63:0] wdata;
    int stl, bsy;
  } vec_t;
  vec_t vt[13];
  int mc_hits[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_hit(input logic [4:0] rd);
    if (rd == 5'd31) return 1'b0;
    foreach (wbq[i]) if (wbq[i].rg == rd) return 1'b1;
    foreach (mcq[i]) if (mcq[i].rg == rd) return 1'b1;
    return exp_rw && exp_wreg == rd;
  endfunction
  task automatic model_check();
    if (!reset) begin
      chk("wb_ready", 64'(ifc.wb_ready), 64'(wbq.size() < 2));
      chk("mc_ready", 64'(ifc.mc_ready), 64'(mcq.size() < 2));
    end
    chk("RegWrite", 64'(ifc.RegWrite), 64'(exp_rw && !reset));
    if (exp_rw && !reset) begin
      chk("WriteRegister", 64'(ifc.WriteRegister), 64'(exp_wreg));
      chk("WriteData", ifc.WriteData, exp_wdata);
    end
    chk("busy", 64'(ifc.busy), 64'(!reset && (wbq.size() != 0 || mcq.size() != 0 || exp_rw)));
    chk("stall", 64'(ifc.stall), 64'(!reset && (m_hit(ifc.rd_reg1) || m_hit(ifc.rd_reg2))));
  endtask
  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic model_update();
    wr_req_t h;
    bit wacc, macc, mne, gm, g;
    if (reset) begin
      wbq.delete();
      mcq.delete();
      sc = 0;
      exp_rw = 1'b0;
      return;
    end
    wacc = ifc.wb_valid && wbq.size() < 2;
    macc = ifc.mc_valid && mcq.size() < 2;
    mne  = mcq.size() != 0;
    gm   = mne && (wbq.size() == 0 || (STARVE && sc == LIMIT));
    g    = gm || wbq.size() != 0;
    h    = '0;
    if (gm) h = mcq.pop_front();
    else if (g) h = wbq.pop_front();
    sc = (STARVE && mne && !gm) ? sc + 1 : 0;
    exp_rw    = g && h.rg != 5'd31;
    exp_wreg  = h.rg;
    exp_wdata = h.data;
    if (wacc) wbq.push_back({ifc.wb_reg, ifc.wb_data});
    if (macc) mcq.push_back({ifc.mc_reg, ifc.mc_data});
  endtask
  task automatic fin();
    model_update();
    @(negedge clk);
  endtask
  task automatic idle();
    ifc.wb_valid = 1'b0; ifc.wb_reg = 5'd0; ifc.wb_data = 64'd0;
    ifc.mc_valid = 1'b0; ifc.mc_reg = 5'd0; ifc.mc_data = 64'd0;
    ifc.rd_reg1 = 5'd31; ifc.rd_reg2 = 5'd31;
  endtask
  initial begin
    idle();
    //          r  wv wr  wd          mv mr md       rd1 rd2 rw wreg wdata       stl bsy
    vt[0]  = '{1, 0, 0,  64'd0,      0, 0, 64'd0,   0,  0,  0, 0,   64'd0,      0, 0};
    vt[1]  = '{1, 0, 0,  64'd0,      0, 0, 64'd0,   0,  0,  0, 0,   64'd0,      0, 0};
    vt[2]  = '{0, 1, 5,  64'hDEAD,   0, 0, 64'd0,   5,  0,  0, 0,   64'd0,      0, 0};
    vt[3]  = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   5,  0,  0, 0,   64'd0,      1, 1};
    vt[4]  = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   5,  0,  1, 5,   64'hDEAD,   1, 1};
    vt[5]  = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   5,  0,  0, 0,   64'd0,      0, 0};
    vt[6]  = '{0, 1, 31, 64'h1234,   0, 0, 64'd0,   31, 31, 0, 0,   64'd0,      0, 0};
    vt[7]  = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   31, 31, 0, 0,   64'd0,      0, 1};
    vt[8]  = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   31, 31, 0, 0,   64'd0,      0, 0};
    vt[9]  = '{0, 0, 0,  64'd0,      1, 7, 64'h77,  7,  31, 0, 0,   64'd0,      0, 0};
    vt[10] = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   7,  31, 0, 0,   64'd0,      1, 1};
    vt[11] = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   7,  31, 1, 7,   64'h77,     1, 1};
    vt[12] = '{0, 0, 0,  64'd0,      0, 0, 64'd0,   7,  31, 0, 0,   64'd0,      0, 0};
    @(negedge clk);
    foreach (vt[k]) begin
      reset = vt[k].r[0];
      ifc.wb_valid = vt[k].wv[0]; ifc.wb_reg = 5'(vt[k].wr); ifc.wb_data = vt[k].wd;
      ifc.mc_valid = vt[k].mv[0]; ifc.mc_reg = 5'(vt[k].mr); ifc.mc_data = vt[k].md;
      ifc.rd_reg1 = 5'(vt[k].rd1); ifc.rd_reg2 = 5'(vt[k].rd2);
      #1;
      model_check();
      chk("tbl_RegWrite", 64'(ifc.RegWrite), 64'(vt[k].rw));
      if (vt[k].rw != 0) begin
        chk("tbl_WriteRegister", 64'(ifc.WriteRegister), 64'(vt[k].wreg));
        chk("tbl_WriteData", ifc.WriteData, vt[k].wdata);
      end
      chk("tbl_stall", 64'(ifc.stall), 64'(vt[k].stl));
      chk("tbl_busy", 64'(ifc.busy), 64'(vt[k].bsy));
      if (vt[k].r == 0) begin
        chk("tbl_wb_ready", 64'(ifc.wb_ready), 64'd1);
        chk("tbl_mc_ready", 64'(ifc.mc_ready), 64'd1);
      end
      fin();
    end
    // Both requesters saturating: mc fills after two accepts, grants follow the priority rule.
    for (int c = 0; c < 40; c++) begin
      ifc.wb_valid = 1'b1; ifc.wb_reg = 5'd1; ifc.wb_data = 64'(c);
      ifc.mc_valid = 1'b1; ifc.mc_reg = 5'd2; ifc.mc_data = 64'h100 + 64'(c);
      ifc.rd_reg1 = 5'd31; ifc.rd_reg2 = 5'd31;
      #1;
      model_check();
      if (c == 2 || c == 3) chk("mc_ready_full", 64'(ifc.mc_ready), 64'd0);
      if (ifc.RegWrite && ifc.WriteRegister == 5'd2) mc_hits.push_back(c);
      fin();
    end
`ifdef REGWRITE_ARB_STARVE_EN
    chk("mc_grant_count", 64'(mc_hits.size() >= 6), 64'd1);
    for (int i = 1; i < mc_hits.size(); i++)
      chk("mc_grant_spacing", 64'(mc_hits[i] - mc_hits[i-1]), 64'd5);
`else
    chk("mc_grant_count", 64'(mc_hits.size()), 64'd0);
`endif
    // Reset with loaded FIFOs and live requests: everything is dropped.
    reset = 1'b1;
    #1;
    model_check();
    fin();
    reset = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      #1;
      model_check();
      chk("post_rst_RegWrite", 64'(ifc.RegWrite), 64'd0);
      chk("post_rst_busy", 64'(ifc.busy), 64'd0);
      chk("post_rst_wb_ready", 64'(ifc.wb_ready), 64'd1);
      chk("post_rst_mc_ready", 64'(ifc.mc_ready), 64'd1);
      fin();
    end
    // Random traffic on a small register set so hazards and collisions are frequent.
    for (int c = 0; c < 800; c++) begin
      int r1, r2, a, b;
      reset = $urandom_range(0, 79) == 0;
      a = $urandom_range(0, 8); b = $urandom_range(0, 8);
      r1 = $urandom_range(0, 8); r2 = $urandom_range(0, 8);
      ifc.wb_valid = $urandom_range(0, 3) != 0;
      ifc.wb_reg = (a == 8) ? 5'd31 : 5'(a);
      ifc.wb_data = {$urandom, $urandom};
      ifc.mc_valid = $urandom_range(0, 2) == 0;
      ifc.mc_reg = (b == 8) ? 5'd31 : 5'(b);
      ifc.mc_data = {$urandom, $urandom};
      ifc.rd_reg1 = (r1 == 8) ? 5'd31 : 5'(r1);
      ifc.rd_reg2 = (r2 == 8) ? 5'd31 : 5'(r2);
      #1;
      model_check();
      fin();
    end
    reset = 1'b0;
    idle();
    for (int c = 0; c < 8; c++) begin
      #1;
      model_check();
      fin();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost grants after which mc wins.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb_valid/wb_ready  input/output  1  handshake for the writeback-stage write request.
REQ-005 SHALL have ports wb_reg  input  5 and wb_data  input  64, the writeback target register and value.
REQ-006 SHALL have ports mc_valid/mc_ready  input/output  1  handshake for the multi-cycle unit (MUL/LDR return) request.
REQ-007 SHALL have ports mc_reg  input  5 and mc_data  input  64, the multi-cycle target register and value.
REQ-008 SHALL have ports RegWrite  output  1, WriteRegister  output  5 and WriteData  output  64, driving the register file write port.
REQ-009 SHALL have ports rd_reg1, rd_reg2  input  5, the decode-stage read register numbers.
REQ-010 SHALL have port stall  output  1, a read-after-pending-write hazard flag.
REQ-011 SHALL have port busy  output  1, asserted when any request is buffered or issuing.

Function
REQ-012 SHALL accept a request on the rising edge where valid and ready are both high, pushing it into that requester's 2-entry FIFO.
REQ-013 SHALL drive ready = FIFO not full, with no same-cycle pass-through, so a full FIFO deasserts ready even when popping.
REQ-014 SHALL grant one non-empty FIFO head per cycle: wb by default; mc when only mc is non-empty or the starvation guard fires.
REQ-015 SHALL pop the granted head and load it into the output register, asserting RegWrite with WriteRegister/WriteData in the next cycle.
REQ-016 SHALL impose latency: accept at edge N -> RegWrite high during cycle N+2 when uncontended; sustained throughput one write per cycle.
REQ-017 SHALL hold RegWrite low in any cycle following a cycle with no grant.
REQ-018 SHALL accept requests targeting register 31, pop and discard them, and never assert RegWrite for them.
REQ-019 SHALL count consecutive cycles in which mc is non-empty but not granted; at count == STARVE_LIMIT mc is granted and the count clears.
REQ-020 SHALL clear the starvation count whenever mc is granted or the mc FIFO is empty.
REQ-021 SHALL assert stall combinationally when rd_reg1 or rd_reg2 (non-31) matches any valid FIFO entry or the valid output register.
REQ-022 SHALL issue two requests to the same register in grant order; cross-requester ordering is governed solely by REQ-014/REQ-019.

Reset
REQ-023 SHALL, on reset, empty both FIFOs, discard any pending write, and zero the starvation count.
REQ-024 SHALL, during and the cycle after reset, drive RegWrite=0, WriteRegister=0, WriteData=0, stall=0, busy=0 and wb_ready=mc_ready=1 (after release).
REQ-025 SHALL give reset priority over simultaneous handshakes; requests presented in the reset cycle are dropped.

Configuration
REQ-026 SHALL, with REGWRITE_ARB_STARVE_EN defined, implement REQ-019/REQ-020 as specified.
REQ-027 SHALL, without REGWRITE_ARB_STARVE_EN, omit the counter and use strict wb-over-mc priority.

Structure
REQ-028 SHALL place typedef wr_req_t (5-bit register, 64-bit data), constant XZR = 31 and FIFO depth 2 in package regarb_pkg.
REQ-029 SHALL implement each FIFO as sub-module wr_fifo2, instantiated once per requester.

Verification
REQ-030 SHALL cover: single wb write X5=0xDEAD -> RegWrite high two cycles later with WriteRegister=5, WriteData=0xDEAD, one cycle only.
REQ-031 SHALL cover: wb and mc valid continuously, macro defined -> mc granted exactly every 5th cycle; undefined -> mc never granted while wb non-empty.
REQ-032 SHALL cover: request to X31 -> accepted, busy pulses, RegWrite stays 0.
REQ-033 SHALL cover: three back-to-back mc pushes while wb is saturating -> mc_ready low after second accept until a pop.
REQ-034 SHALL cover: X7 buffered, rd_reg1=7 -> stall=1 until the cycle after RegWrite for X7; rd_reg2=31 never stalls.
REQ-035 SHALL cover: reset asserted with both FIFOs full -> next cycle RegWrite=0, busy=0, both ready=1, no buffered write ever issues.
